alu_seq_unit: RTL



---
 rtl/alu_seq_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: execute-stage ALU, 1-cycle ops plus a shift-add MUL with start/busy/done handshake.
// Define ALU_MUL_EARLY_EXIT_EN to end MUL once the remaining multiplier is zero.
module alu_seq_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [4:0]       shamt,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done
);
   typedef enum logic {S_IDLE, S_MUL} state_t;
   localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_AND = 4'b0000,
                          OP_OR  = 4'b0001, OP_NOR = 4'b1100, OP_SLT = 4'b0111,
                          OP_SLL = 4'b0011, OP_SRL = 4'b1011, OP_MUL = 4'b1111;
   state_t           state_q;
   logic [WIDTH-1:0] result_q, res_d, mcand_q, mplier_q, acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             zero_q, done_q, fin;
   always_comb begin
      res_d = '0;
      case (alucontrol)
         OP_ADD:  res_d = a + b;
         OP_SUB:  res_d = a - b;
         OP_AND:  res_d = a & b;
         OP_OR:   res_d = a | b;
         OP_NOR:  res_d = ~(a | b);
         OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLL:  res_d = b << shamt;
         OP_SRL:  res_d = b >> shamt;
         default: res_d = '0;
      endcase
   end
`ifdef ALU_MUL_EARLY_EXIT_EN
   assign fin = (cnt_q == CNT_W'(WIDTH)) || (mplier_q == '0);
`else
   assign fin = cnt_q == CNT_W'(WIDTH);
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start) begin
               if (alucontrol == OP_MUL) begin
                  mcand_q  <= a;
                  mplier_q <= b;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= S_MUL;
               end else begin
                  result_q <= res_d;
                  zero_q   <= res_d == '0;
                  done_q   <= 1'b1;
               end
            end
            default: if (fin) begin
               result_q <= acc_q;
               zero_q   <= acc_q == '0;
               done_q   <= 1'b1;
               state_q  <= S_IDLE;
            end else begin
               if (mplier_q[0]) acc_q <= acc_q + mcand_q;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1);
            end
         endcase
      end
   end
   assign result = result_q;
   assign zero   = zero_q;
   assign busy   = state_q == S_MUL;
   assign done   = done_q;
endmodule
